// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer: walks every TLB entry once per request and clears the E bit
// of each valid entry that matches the latched FlushOp, holding busy until done.
module tlb_inv_seq #(
   parameter int unsigned TLBNUM      = 16,
   parameter int unsigned TLBNUMSIZE  = $clog2(TLBNUM),
   localparam int unsigned OP_W       = 3,
   localparam int unsigned ASID_W     = 10,
   localparam int unsigned VA_W       = 32,
   localparam int unsigned PS_W       = 6,
   localparam int unsigned VPPN_W     = 19
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_W-1:0]       op,
   input  logic [ASID_W-1:0]     asid,
   input  logic [VA_W-1:0]       va,
   output logic [TLBNUMSIZE-1:0] rd_idx,
   input  logic                  rd_e,
   input  logic                  rd_g,
   input  logic [ASID_W-1:0]     rd_asid,
   input  logic [PS_W-1:0]       rd_ps,
   input  logic [VPPN_W-1:0]     rd_vppn,
   output logic                  inv_we,
   output logic [TLBNUMSIZE-1:0] inv_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned HUGE_VPN_W = 10;
   localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);
   localparam logic [OP_W-1:0]       OP_ILLEGAL = OP_W'(7);
   localparam logic [PS_W-1:0]       PS_4K = PS_W'(12);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [TLBNUMSIZE-1:0]   rd_idx_q, rd_idx_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [OP_W-1:0]         op_q, op_d;
   logic [ASID_W-1:0]       asid_q, asid_d;
   logic [VPPN_W-1:0]       vpn_q, vpn_d;

   // Only the page-number part of the operand address takes part in matching.
   logic unused_va_lo;
   assign unused_va_lo = ^va[VA_W-VPPN_W-1:0];

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rd_idx_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         op_q     <= '0;
         asid_q   <= '0;
         vpn_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_idx_q <= rd_idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         op_q     <= op_d;
         asid_q   <= asid_d;
         vpn_q    <= vpn_d;
      end
   end

   // Next state; busy/done/err are computed for the coming state so they register cleanly.
   always_comb begin
      state_d  = state_q;
      rd_idx_d = rd_idx_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      op_d     = op_q;
      asid_d   = asid_q;
      vpn_d    = vpn_q;
      case (state_q)
         ST_IDLE: begin
            rd_idx_d = '0;
            if (start) begin
               if (op == OP_ILLEGAL) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_WALK;
                  busy_d  = 1'b1;
                  op_d    = op;
                  asid_d  = asid;
                  vpn_d   = va[VA_W-1:VA_W-VPPN_W];
               end
            end
         end
         ST_WALK: begin
            if (rd_idx_q == LAST_IDX) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               rd_idx_d = '0;
            end else begin
               rd_idx_d = rd_idx_q + TLBNUMSIZE'(1);
               busy_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            rd_idx_d = '0;
         end
         default: begin
            state_d  = ST_IDLE;
            rd_idx_d = '0;
         end
      endcase
   end

   logic asid_hit_c;
   logic va_hit_c;
   logic match_c;

   // FlushOp rule applied to the entry currently on the read port.
   always_comb begin
      asid_hit_c = (rd_asid == asid_q);
      if (rd_ps == PS_4K) begin
         va_hit_c = (rd_vppn == vpn_q);
      end else begin
         va_hit_c = (rd_vppn[VPPN_W-1:VPPN_W-HUGE_VPN_W] == vpn_q[VPPN_W-1:VPPN_W-HUGE_VPN_W]);
      end
      case (op_q)
         3'd0, 3'd1: match_c = 1'b1;
         3'd2:       match_c = rd_g;
         3'd3:       match_c = !rd_g;
         3'd4:       match_c = !rd_g && asid_hit_c;
         3'd5:       match_c = !rd_g && asid_hit_c && va_hit_c;
         3'd6:       match_c = (rd_g || asid_hit_c) && va_hit_c;
         default:    match_c = 1'b0;
      endcase
   end

   assign inv_we  = (state_q == ST_WALK) && match_c && rd_e;
   assign inv_idx = rd_idx_q;
   assign rd_idx  = rd_idx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Randomized bench for tlb_inv_seq: emulates a 16-entry TLB on the read/invalidate
// ports and checks every cycle of each request against a FlushOp reference model.
module tb_tlb_inv_seq;

   localparam int unsigned N  = 16;
   localparam int unsigned IW = $clog2(N);

   typedef struct packed {
      logic        e;
      logic        g;
      logic [9:0]  asid;
      logic [5:0]  ps;
      logic [18:0] vppn;
   } ent_t;

   logic          aclk;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [9:0]    asid;
   logic [31:0]   va;
   logic [IW-1:0] rd_idx;
   logic          rd_e;
   logic          rd_g;
   logic [9:0]    rd_asid;
   logic [5:0]    rd_ps;
   logic [18:0]   rd_vppn;
   logic          inv_we;
   logic [IW-1:0] inv_idx;
   logic          busy;
   logic          done;
   logic          err;

   ent_t          tlb [N];
   bit            exp_e [N];
   bit            pend;
   logic [IW-1:0] pend_idx;
   int            n_checks;
   int            n_pass;

   tlb_inv_seq #(.TLBNUM(N)) dut (
      .aclk    (aclk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .asid    (asid),
      .va      (va),
      .rd_idx  (rd_idx),
      .rd_e    (rd_e),
      .rd_g    (rd_g),
      .rd_asid (rd_asid),
      .rd_ps   (rd_ps),
      .rd_vppn (rd_vppn),
      .inv_we  (inv_we),
      .inv_idx (inv_idx),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Emulated TLB read port.
   always_comb begin
      rd_e    = tlb[rd_idx].e;
      rd_g    = tlb[rd_idx].g;
      rd_asid = tlb[rd_idx].asid;
      rd_ps   = tlb[rd_idx].ps;
      rd_vppn = tlb[rd_idx].vppn;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Sample the invalidate at mid-cycle, let the emulated TLB apply it just after the edge.
   task automatic tick();
      if (inv_we === 1'b1) begin
         pend     = 1'b1;
         pend_idx = inv_idx;
      end
      @(posedge aclk);
      #1;
      if (pend) begin
         tlb[pend_idx].e = 1'b0;
         pend = 1'b0;
      end
      @(negedge aclk);
   endtask

   function automatic bit model_hit(input int o, input logic [9:0] a, input logic [31:0] v,
                                    input ent_t t);
      bit ah, vh;
      ah = (t.asid == a);
      if (t.ps == 6'd12) vh = (t.vppn == v[31:13]);
      else               vh = (t.vppn[18:9] == v[31:22]);
      case (o)
         0, 1:    return 1'b1;
         2:       return t.g;
         3:       return !t.g;
         4:       return !t.g && ah;
         5:       return !t.g && ah && vh;
         6:       return (t.g || ah) && vh;
         default: return 1'b0;
      endcase
   endfunction

   function automatic ent_t rand_ent(input logic [9:0] a, input logic [31:0] v, input bit rand_e);
      ent_t t;
      int   sel;
      t.e  = rand_e ? ($urandom_range(0, 3) != 0) : 1'b1;
      t.g  = 1'($urandom);
      sel  = $urandom_range(0, 2);
      t.asid = (sel == 0) ? a : (sel == 1) ? (a ^ 10'h1) : 10'($urandom);
      t.ps = ($urandom_range(0, 1) == 1) ? 6'd12 : 6'd21;
      if ($urandom_range(0, 2) == 0)  t.vppn = 19'($urandom);
      else if (t.ps == 6'd12)         t.vppn = v[31:13];
      else                            t.vppn = {v[31:22], 9'($urandom)};
      return t;
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, ".busy"},   32'(busy),   32'd0);
      check_eq({tag, ".done"},   32'(done),   32'd0);
      check_eq({tag, ".err"},    32'(err),    32'd0);
      check_eq({tag, ".rd_idx"}, 32'(rd_idx), 32'd0);
      check_eq({tag, ".inv_we"}, 32'(inv_we), 32'd0);
   endtask

   task automatic check_ebits(input string tag);
      for (int i = 0; i < N; i++)
         check_eq($sformatf("%s.e[%0d]", tag, i), 32'(tlb[i].e), 32'(exp_e[i]));
   endtask

   // One request from start to retirement; abort_k >= 0 asserts reset during walk step abort_k.
   task automatic run_req(input string tag, input logic [2:0] o, input logic [9:0] a,
                          input logic [31:0] v, input int abort_k, input bit noisy);
      bit hit [N];
      for (int i = 0; i < N; i++) begin
         exp_e[i] = tlb[i].e;
         hit[i]   = model_hit(int'(o), a, v, tlb[i]) && tlb[i].e;
      end
      reset = 1'b0;
      start = 1'b1;
      op    = o;
      asid  = a;
      va    = v;
      tick();
      start = 1'b0;
      if (noisy) begin
         op   = 3'($urandom);
         asid = 10'($urandom);
         va   = $urandom;
      end
      if (o == 3'd7) begin
         check_eq({tag, ".ill_done"}, 32'(done),   32'd1);
         check_eq({tag, ".ill_err"},  32'(err),    32'd1);
         check_eq({tag, ".ill_busy"}, 32'(busy),   32'd0);
         check_eq({tag, ".ill_we"},   32'(inv_we), 32'd0);
         if (noisy) start = 1'($urandom);
         tick();
         start = 1'b0;
         check_idle({tag, ".post"});
         check_ebits(tag);
         return;
      end
      for (int k = 0; k < N; k++) begin
         check_eq($sformatf("%s.idx%0d", tag, k),  32'(rd_idx),  32'(k));
         check_eq($sformatf("%s.iidx%0d", tag, k), 32'(inv_idx), 32'(k));
         check_eq($sformatf("%s.busy%0d", tag, k), 32'(busy),    32'd1);
         check_eq($sformatf("%s.done%0d", tag, k), 32'(done),    32'd0);
         check_eq($sformatf("%s.we%0d", tag, k),   32'(inv_we),  32'(hit[k]));
         if (hit[k]) exp_e[k] = 1'b0;
         if (noisy) begin
            start = 1'($urandom);
            op    = 3'($urandom);
            asid  = 10'($urandom);
            va    = $urandom;
         end
         if (k == abort_k) begin
            reset = 1'b1;
            start = 1'b0;
            tick();
            reset = 1'b0;
            check_idle({tag, ".abort"});
            check_ebits(tag);
            return;
         end
         tick();
      end
      check_eq({tag, ".done"},   32'(done),   32'd1);
      check_eq({tag, ".err"},    32'(err),    32'd0);
      check_eq({tag, ".dbusy"},  32'(busy),   32'd0);
      check_eq({tag, ".didx"},   32'(rd_idx), 32'd0);
      check_eq({tag, ".dwe"},    32'(inv_we), 32'd0);
      if (noisy) start = 1'($urandom);
      tick();
      start = 1'b0;
      check_idle({tag, ".post"});
      check_ebits(tag);
   endtask

   initial begin
      logic [9:0]  a;
      logic [31:0] v;
      n_checks = 0;
      n_pass   = 0;
      pend     = 1'b0;
      pend_idx = '0;
      reset    = 1'b1;
      start    = 1'b0;
      op       = '0;
      asid     = '0;
      va       = '0;
      for (int i = 0; i < N; i++) tlb[i] = '0;
      tick();
      tick();
      check_idle("reset");
      reset = 1'b0;
      tick();

      // Flush everything.
      for (int i = 0; i < N; i++) tlb[i] = rand_ent(10'h3, 32'h1234_5678, 1'b0);
      run_req("all", 3'd0, 10'h3, 32'h1234_5678, -1, 1'b0);

      // Global-only and non-global-only flushes.
      for (int i = 0; i < N; i++) begin
         tlb[i]   = rand_ent(10'h11, 32'hdead_b000, 1'b0);
         tlb[i].g = (i == 3 || i == 5);
      end
      run_req("g1", 3'd2, 10'h11, 32'hdead_b000, -1, 1'b0);
      for (int i = 0; i < N; i++) begin
         tlb[i]   = rand_ent(10'h11, 32'hdead_b000, 1'b0);
         tlb[i].g = (i == 3 || i == 5);
      end
      run_req("g0", 3'd3, 10'h11, 32'hdead_b000, -1, 1'b0);

      // ASID + VA on non-global entries.
      v = 32'h8765_4000;
      for (int i = 0; i < N; i++) begin
         tlb[i]   = rand_ent(10'h2a, v, 1'b0);
         tlb[i].g = 1'b1;
      end
      tlb[7] = '{e: 1'b1, g: 1'b0, asid: 10'h2a, ps: 6'd12, vppn: v[31:13]};
      tlb[8] = '{e: 1'b1, g: 1'b0, asid: 10'h2b, ps: 6'd12, vppn: v[31:13]};
      run_req("op5", 3'd5, 10'h2a, v, -1, 1'b0);

      // Huge-page VA hit via G despite ASID mismatch.
      v = 32'h5a5a_5000;
      for (int i = 0; i < N; i++)
         tlb[i] = '{e: 1'b1, g: 1'b0, asid: 10'h100, ps: 6'd12, vppn: ~v[31:13]};
      tlb[9] = '{e: 1'b1, g: 1'b1, asid: 10'h155, ps: 6'd21, vppn: {v[31:22], ~v[21:13]}};
      run_req("op6", 3'd6, 10'h2a, v, -1, 1'b0);

      // Illegal op, then a normal walk.
      for (int i = 0; i < N; i++) tlb[i] = rand_ent(10'h7, 32'h0, 1'b0);
      run_req("ill", 3'd7, 10'h7, 32'h0, -1, 1'b0);
      run_req("after_ill", 3'd0, 10'h7, 32'h0, -1, 1'b0);

      // Reset mid-walk, then an immediate new request.
      for (int i = 0; i < N; i++) tlb[i] = rand_ent(10'h9, 32'h0, 1'b0);
      run_req("abort", 3'd1, 10'h9, 32'h0, 5, 1'b0);
      run_req("after_abort", 3'd0, 10'h9, 32'h0, -1, 1'b0);

      // Randomized requests with operand noise and stray start pulses.
      for (int r = 0; r < 30; r++) begin
         a = 10'($urandom);
         v = $urandom;
         for (int i = 0; i < N; i++) tlb[i] = rand_ent(a, v, 1'b1);
         run_req($sformatf("rnd%0d", r), 3'($urandom_range(0, 7)), a, v, -1, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
